tx_fifo_sync: RTL and testbench

TX_FIFO_SYNC -- requirements
Module: tx_fifo_sync

---
 rtl/tx_fifo_sync.sv | 94 +++++++++
 tb/tb_tx_fifo_sync.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/tx_fifo_sync.sv
// Single-clock FIFO: wide words go in, narrow bytes come out, least-significant byte first.
// Flags come from registered byte/word levels, so they change one edge after the causing transfer.
module tx_fifo_sync #(
   parameter int WR_DATA_WIDTH    = 128,
   parameter int WR_DEPTH_WIDTH   = 8,
   parameter int RD_DATA_WIDTH    = 8,
   parameter int RD_DEPTH_WIDTH   = 12,
   parameter int ALMOST_FULL_NUM  = 15,
   parameter int ALMOST_EMPTY_NUM = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [WR_DATA_WIDTH-1:0] wr_data,
   input  logic                     wr_en,
   output logic                     wr_full,
   output logic                     almost_full,
   output logic [RD_DATA_WIDTH-1:0] rd_data,
   input  logic                     rd_en,
   output logic                     rd_empty,
   output logic                     almost_empty
);

   localparam int BYTES = WR_DATA_WIDTH / RD_DATA_WIDTH;
   localparam int SEL_W = RD_DEPTH_WIDTH - WR_DEPTH_WIDTH;
   localparam int WORDS = 1 << WR_DEPTH_WIDTH;
   localparam int RL_W  = RD_DEPTH_WIDTH + 1;
   localparam int WL_W  = WR_DEPTH_WIDTH + 1;

   localparam logic [WL_W-1:0] WL_FULL  = WL_W'(WORDS);
   localparam logic [WL_W-1:0] AF_LVL   = WL_W'(ALMOST_FULL_NUM);
   localparam logic [RL_W-1:0] AE_LVL   = RL_W'(ALMOST_EMPTY_NUM);
   localparam logic [RL_W-1:0] RL_WORD  = RL_W'(BYTES);
   localparam logic [RL_W-1:0] RL_ROUND = RL_W'(BYTES - 1);

   logic [WR_DATA_WIDTH-1:0]  mem [WORDS];
   logic [WR_DEPTH_WIDTH-1:0] wr_ptr_reg;
   logic [RD_DEPTH_WIDTH-1:0] rd_ptr_reg;
   logic [RL_W-1:0]           rd_level_reg, rd_level_next;
   logic [WL_W-1:0]           wr_level_reg, wr_level_next;
   logic [RD_DATA_WIDTH-1:0]  rd_data_reg;
   logic [WR_DATA_WIDTH-1:0]  head_word;
   logic [RD_DATA_WIDTH-1:0]  lane [BYTES];
   logic                      wr_acc, rd_acc;

   assign wr_full      = (wr_level_reg == WL_FULL);
   assign almost_full  = (wr_level_reg >= AF_LVL);
   assign rd_empty     = (rd_level_reg == '0);
   assign almost_empty = (rd_level_reg <= AE_LVL);
   assign rd_data      = rd_data_reg;

   // Acceptance uses pre-edge flags: a write while full stays blocked even if a read frees space.
   assign wr_acc = wr_en & ~wr_full;
   assign rd_acc = rd_en & ~rd_empty;

   always_comb begin
      rd_level_next = rd_level_reg;
      if (wr_acc) rd_level_next = rd_level_next + RL_WORD;
      if (rd_acc) rd_level_next = rd_level_next - RL_W'(1);
   end

   // A partially read word still holds its slot, so word level rounds up.
   assign wr_level_next = WL_W'((rd_level_next + RL_ROUND) >> SEL_W);

   assign head_word = mem[rd_ptr_reg[RD_DEPTH_WIDTH-1:SEL_W]];

   generate
      for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
         assign lane[gi] = head_word[gi*RD_DATA_WIDTH +: RD_DATA_WIDTH];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr_reg] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         rd_level_reg <= '0;
         wr_level_reg <= '0;
         rd_data_reg  <= '0;
      end else begin
         rd_level_reg <= rd_level_next;
         wr_level_reg <= wr_level_next;
         if (wr_acc) wr_ptr_reg <= wr_ptr_reg + WR_DEPTH_WIDTH'(1);
         if (rd_acc) begin
            rd_data_reg <= lane[rd_ptr_reg[SEL_W-1:0]];
            rd_ptr_reg  <= rd_ptr_reg + RD_DEPTH_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_tx_fifo_sync.sv
// Directed bench for tx_fifo_sync: a vector table for basic byte order and flags,
// plus hand sequences for full/almost-full boundaries and mid-read reset.
module tb_tx_fifo_sync;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [127:0] wr_data;
   logic         wr_en;
   logic         wr_full;
   logic         almost_full;
   logic [7:0]   rd_data;
   logic         rd_en;
   logic         rd_empty;
   logic         almost_empty;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tx_fifo_sync dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_data      (wr_data),
      .wr_en        (wr_en),
      .wr_full      (wr_full),
      .almost_full  (almost_full),
      .rd_data      (rd_data),
      .rd_en        (rd_en),
      .rd_empty     (rd_empty),
      .almost_empty (almost_empty)
   );

   typedef struct {
      logic         we;
      logic         re;
      logic [127:0] d;
      logic         e_full;
      logic         e_af;
      logic         e_empty;
      logic         e_ae;
      logic [7:0]   e_rd;
   } vec_t;

   vec_t vt[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] make_word(input int base);
      logic [127:0] w;
      for (int k = 0; k < 16; k++) w[k*8 +: 8] = 8'(base + k);
      return w;
   endfunction

   function automatic logic [7:0] bword(input int i, input int k);
      return 8'(i * 3 + k * 17);
   endfunction

   function automatic logic [127:0] big_word(input int i);
      logic [127:0] w;
      for (int k = 0; k < 16; k++) w[k*8 +: 8] = bword(i, k);
      return w;
   endfunction

   task automatic add(input logic we, input logic re, input logic [127:0] d, input logic f,
                      input logic af, input logic em, input logic ae, input logic [7:0] rd);
      vec_t v;
      v.we = we; v.re = re; v.d = d;
      v.e_full = f; v.e_af = af; v.e_empty = em; v.e_ae = ae; v.e_rd = rd;
      vt.push_back(v);
   endtask

   task automatic cyc(input logic we, input logic re, input logic [127:0] d);
      wr_en = we; rd_en = re; wr_data = d;
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check({tag, "_rst_empty"}, 32'(rd_empty), 32'd1);
      check({tag, "_rst_full"},  32'(wr_full),  32'd0);
      check({tag, "_rst_data"},  32'(rd_data),  32'd0);
      rst_n = 1'b1;
   endtask

   initial begin
      // Table: one word 0x0F..00 read out byte by byte, then over-read, then mixed write/read.
      add(0, 0, '0, 0, 0, 1, 1, 8'h00);
      add(1, 0, make_word(0), 0, 0, 0, 0, 8'h00);
      for (int k = 1; k <= 16; k++)
         add(0, 1, '0, 0, 0, (k == 16), ((16 - k) <= 4), 8'(k - 1));
      add(0, 1, '0, 0, 0, 1, 1, 8'h0F);
      add(1, 0, make_word(8'h10), 0, 0, 0, 0, 8'h0F);
      add(1, 1, make_word(8'h20), 0, 0, 0, 0, 8'h10);
      add(0, 1, '0, 0, 0, 0, 0, 8'h11);

      do_reset("tbl");
      check("tbl_rst_ae", 32'(almost_empty), 32'd1);
      check("tbl_rst_af", 32'(almost_full),  32'd0);
      foreach (vt[i]) begin
         cyc(vt[i].we, vt[i].re, vt[i].d);
         check($sformatf("v%0d_full", i),  32'(wr_full),      32'(vt[i].e_full));
         check($sformatf("v%0d_af", i),    32'(almost_full),  32'(vt[i].e_af));
         check($sformatf("v%0d_empty", i), 32'(rd_empty),     32'(vt[i].e_empty));
         check($sformatf("v%0d_ae", i),    32'(almost_empty), 32'(vt[i].e_ae));
         check($sformatf("v%0d_rd", i),    32'(rd_data),      32'(vt[i].e_rd));
      end

      // Almost-full threshold: 15 words sets it, it clears once word level drops to 14.
      do_reset("af");
      for (int i = 0; i < 15; i++) begin
         cyc(1, 0, make_word(i));
         check($sformatf("af_w%0d", i), 32'(almost_full), 32'(i == 14));
      end
      for (int k = 0; k < 16; k++) begin
         cyc(0, 1, '0);
         check($sformatf("af_r%0d", k), 32'(almost_full), 32'(k != 15));
         check($sformatf("af_rd%0d", k), 32'(rd_data), 32'(k));
      end

      // Fill completely, try to overwrite, then drain while checking every byte.
      do_reset("full");
      for (int i = 0; i < 256; i++) begin
         cyc(1, 0, big_word(i));
         check($sformatf("full_w%0d", i), 32'(wr_full), 32'(i == 255));
      end
      cyc(1, 0, {16{8'h5C}});
      check("full_257", 32'(wr_full), 32'd1);
      check("full_257_ae", 32'(almost_empty), 32'd0);
      for (int k = 0; k < 16; k++) begin
         cyc(1, 1, {16{8'h5C}});
         check($sformatf("full_wr_r%0d", k), 32'(wr_full), 32'(k != 15));
         check($sformatf("full_rd0_%0d", k), 32'(rd_data), 32'(bword(0, k)));
      end
      for (int i = 1; i < 256; i++) begin
         for (int k = 0; k < 16; k++) begin
            cyc(0, 1, '0);
            check($sformatf("drain_rd%0d_%0d", i, k), 32'(rd_data), 32'(bword(i, k)));
            check($sformatf("drain_ae%0d_%0d", i, k), 32'(almost_empty),
                  32'(((255 - i) * 16 + 15 - k) <= 4));
         end
      end
      check("drain_empty", 32'(rd_empty), 32'd1);
      check("drain_full",  32'(wr_full),  32'd0);

      // Asynchronous reset in the middle of a read discards everything at once.
      do_reset("mid");
      for (int i = 0; i < 10; i++) cyc(1, 0, make_word(8'h40 + i));
      for (int k = 0; k < 5; k++) cyc(0, 1, '0);
      check("mid_pre_rd", 32'(rd_data), 32'h44);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_empty", 32'(rd_empty),     32'd1);
      check("mid_rd",    32'(rd_data),      32'd0);
      check("mid_full",  32'(wr_full),      32'd0);
      check("mid_ae",    32'(almost_empty), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      cyc(1, 0, make_word(8'hA0));
      check("mid_after_wr", 32'(rd_empty), 32'd0);
      for (int k = 0; k < 16; k++) begin
         cyc(0, 1, '0);
         check($sformatf("mid_rd%0d", k), 32'(rd_data), 32'(8'hA0 + k));
      end
      check("mid_end_empty", 32'(rd_empty), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
